// File: rtl/adder_pair_pkg.sv
// Shared types and widths for the adder operand pairing stage.
package adder_pair_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned OPBUS_W   = 8;
  localparam int unsigned RES_W     = 5;
  localparam int unsigned CARRY_BIT = 4;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    ADD    = 2'd2,
    HOLD   = 2'd3
  } pair_state_t;

endpackage

// File: rtl/adder_pair_kernel.sv
// Combinational 4-bit ripple-carry adder: {B, A} in, {carry, sum} out.
module adder_pair_kernel
  import adder_pair_pkg::*;
(
  input  logic [OPBUS_W-1:0] adder_i,
  output logic [RES_W-1:0]   adder_o
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry   = '0;
    adder_o = '0;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      adder_o[i]   = adder_i[i] ^ adder_i[i+NIBBLE_W] ^ carry[i];
      carry[i+1]   = (adder_i[i] & adder_i[i+NIBBLE_W])
                   | (carry[i] & (adder_i[i] ^ adder_i[i+NIBBLE_W]));
    end
    adder_o[CARRY_BIT] = carry[NIBBLE_W];
  end

endmodule

// File: rtl/adder_pair_top.sv
// Pairer plus the ripple adder kernel; the pairer owns all state.
module adder_pair_top
  import adder_pair_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic [1:0]          clock_reset,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [RES_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    pair_count,
  output logic [CNT_W-1:0]    carry_count
);

  logic [OPBUS_W-1:0] adder_i;
  logic [RES_W-1:0]   adder_o;

  adder_operand_pairer #(.CNT_W(CNT_W)) u_pairer (
    .clock_reset (clock_reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .adder_i     (adder_i),
    .adder_o     (adder_o),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pair_count  (pair_count),
    .carry_count (carry_count)
  );

  adder_pair_kernel u_kernel (
    .adder_i (adder_i),
    .adder_o (adder_o)
  );

endmodule

// File: rtl/adder_operand_pairer.sv
// Pairs incoming nibbles into adder operands, captures the adder result and
// hands it downstream, keeping delivered-pair and carry statistics.
module adder_operand_pairer
  import adder_pair_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic [1:0]          clock_reset,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OPBUS_W-1:0]  adder_i,
  input  logic [RES_W-1:0]    adder_o,
  output logic [RES_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    pair_count,
  output logic [CNT_W-1:0]    carry_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic clk;
  logic rst_n;
  assign clk   = clock_reset[0];
  assign rst_n = clock_reset[1];

  pair_state_t         state;
  logic [NIBBLE_W-1:0] a_reg;
  logic [NIBBLE_W-1:0] b_reg;
  logic [RES_W-1:0]    res_reg;
  logic                in_xfer;
  logic                out_xfer;

  // HOLD forwards out_ready so the next A can land in the same cycle the
  // result leaves; reset masks both handshakes so nothing transfers then.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      WAIT_A, WAIT_B: in_ready = 1'b1;
      HOLD:           in_ready = out_ready;
      default:        in_ready = 1'b0;
    endcase
    if (!rst_n) in_ready = 1'b0;
  end

  assign out_valid = (state == HOLD) && rst_n;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign adder_i   = {b_reg, a_reg};
  assign out_data  = res_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_A;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      pair_count  <= '0;
      carry_count <= '0;
    end else begin
      if (out_xfer) begin
        pair_count <= pair_count + CNT_ONE;
        if (res_reg[CARRY_BIT] && (carry_count != '1))
          carry_count <= carry_count + CNT_ONE;
      end
      case (state)
        WAIT_A: begin
          if (in_xfer) begin
            a_reg <= in_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_xfer) begin
            b_reg <= in_data;
            state <= ADD;
          end
        end
        ADD: begin
          res_reg <= adder_o;
          state   <= HOLD;
        end
        HOLD: begin
          if (in_xfer) begin
            a_reg <= in_data;
            state <= WAIT_B;
          end else if (out_ready) begin
            state <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule
